// File: rtl/instr_stream_loader_pkg.sv
// Shared definitions for the instruction stream loader and the pru_sync core
// whose instruction memory it fills.
//   DEF_DATA_W       : default host stream word width
//   DEF_INSTR_W      : default pru_sync instruction width
//   DEF_INSTR_ADDR_W : default instruction memory address width
//   loader_state_t   : loader FSM state encoding
package instr_stream_loader_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_INSTR_W      = 128;
    localparam int DEF_INSTR_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_stream_loader.sv
// Instruction stream loader: collects WORDS = INSTR_W/DATA_W host words per
// instruction (first word in the LSBs) and writes each assembled instruction
// into the pru_sync instruction memory at consecutive addresses from 0.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, n_instr  : load request and instruction count (sampled in IDLE)
//   in_data, in_vld : host stream word and its valid
//   in_rdy          : loader accepts a word this cycle
//   instr_wr_en/addr/data : instruction memory write port
//   busy            : load in progress (LOAD or WRITE)
//   done            : one-cycle completion pulse
// INSTR_W must be an integer multiple of DATA_W with at least two words.
module instr_stream_loader
    import instr_stream_loader_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int INSTR_W      = DEF_INSTR_W,
    parameter int INSTR_ADDR_W = DEF_INSTR_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [INSTR_ADDR_W:0]   n_instr,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_vld,
    output logic                    in_rdy,
    output logic                    instr_wr_en,
    output logic [INSTR_ADDR_W-1:0] instr_wr_addr,
    output logic [INSTR_W-1:0]      instr_wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int WORDS  = INSTR_W / DATA_W;
    localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    // Full memory depth; needs the extra counter bit so it never reads as 0.
    localparam logic [INSTR_ADDR_W:0] MAX_INSTR = {1'b1, {INSTR_ADDR_W{1'b0}}};

    loader_state_t             state;
    loader_state_t             next_state;
    logic [WCNT_W-1:0]         word_cnt;
    logic [INSTR_ADDR_W:0]     instr_cnt;
    logic [INSTR_ADDR_W:0]     n_latched;
    logic [INSTR_W-1:0]        asm_reg;
    logic [INSTR_ADDR_W:0]     instr_next;
    logic                      xfer;
    logic                      last_word;

    // Requests beyond the memory depth load the whole memory and stop.
    function automatic logic [INSTR_ADDR_W:0] clamp_count(input logic [INSTR_ADDR_W:0] n);
        logic [INSTR_ADDR_W:0] r;
        if (n > MAX_INSTR) begin
            r = MAX_INSTR;
        end else begin
            r = n;
        end
        return r;
    endfunction

    assign xfer       = (state == ST_LOAD) && in_vld;
    assign last_word  = (word_cnt == LAST_WORD);
    assign instr_next = instr_cnt + {{INSTR_ADDR_W{1'b0}}, 1'b1};

    // The write port reads straight from the counter and assembly register,
    // both of which are stable for the whole WRITE cycle.
    assign instr_wr_addr = instr_cnt[INSTR_ADDR_W-1:0];
    assign instr_wr_data = asm_reg;

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (n_instr == '0) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer && last_word) begin
                    next_state = ST_WRITE;
                end else begin
                    next_state = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (instr_next == n_latched) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_LOAD;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered Moore outputs, decoded from next_state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_rdy      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instr_wr_en <= 1'b0;
        end else begin
            state       <= next_state;
            in_rdy      <= (next_state == ST_LOAD);
            busy        <= (next_state == ST_LOAD) || (next_state == ST_WRITE);
            done        <= (next_state == ST_DONE);
            instr_wr_en <= (next_state == ST_WRITE);
        end
    end

    // Counters, latched count and word assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            instr_cnt <= '0;
            n_latched <= '0;
            asm_reg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (n_instr != '0)) begin
                        n_latched <= clamp_count(n_instr);
                        word_cnt  <= '0;
                        instr_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_vld) begin
                        asm_reg[word_cnt*DATA_W +: DATA_W] <= in_data;
                        if (last_word) begin
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_WRITE: begin
                    instr_cnt <= instr_next;
                end
                default: begin
                    word_cnt <= word_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed self-checking bench for instr_stream_loader. Instance u_dut uses the
// default geometry (4 words per instruction, 1024 entries); u_dut_b uses a
// small 8-entry memory with 2 words per instruction for the depth boundary.
module tb_instr_stream_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start_b;
    logic [10:0]  n_instr;
    logic [3:0]   n_b;
    logic [31:0]  in_data, in_data_b;
    logic         in_vld, in_vld_b;
    logic         in_rdy, b_in_rdy;
    logic         wr_en, b_wr_en;
    logic [9:0]   wr_addr;
    logic [2:0]   b_wr_addr;
    logic [127:0] wr_data;
    logic [63:0]  b_wr_data;
    logic         busy, b_busy;
    logic         done, b_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc;

    // Activity logs filled at the falling edge.
    logic [9:0]   wa_q[$];
    logic [127:0] wd_q[$];
    int           wc_q[$];
    int           acc_q[$];
    int           done_cnt, done_cyc, rdy_cnt, busy_cnt;
    logic [2:0]   b_wa_q[$];
    logic [63:0]  b_wd_q[$];
    int           b_wc_q[$];
    int           b_done_cnt, b_done_cyc;

    instr_stream_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .n_instr(n_instr),
        .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .instr_wr_en(wr_en), .instr_wr_addr(wr_addr), .instr_wr_data(wr_data),
        .busy(busy), .done(done)
    );

    instr_stream_loader #(.DATA_W(32), .INSTR_W(64), .INSTR_ADDR_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .n_instr(n_b),
        .in_data(in_data_b), .in_vld(in_vld_b), .in_rdy(b_in_rdy),
        .instr_wr_en(b_wr_en), .instr_wr_addr(b_wr_addr), .instr_wr_data(b_wr_data),
        .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (in_vld && in_rdy) acc_q.push_back(cyc);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (in_rdy) rdy_cnt = rdy_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (b_wr_en) begin
            b_wa_q.push_back(b_wr_addr);
            b_wd_q.push_back(b_wr_data);
            b_wc_q.push_back(cyc);
        end
        if (b_done) begin
            b_done_cnt = b_done_cnt + 1;
            b_done_cyc = cyc;
        end
    end

    // Expected instruction i of a load whose first word is base (4 words).
    function automatic logic [127:0] exp_a(input int base, input int i);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[32*j +: 32] = 32'(base + 4*i + j);
        return r;
    endfunction

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_q.delete();
        done_cnt = 0; done_cyc = -1; rdy_cnt = 0; busy_cnt = 0;
        b_wa_q.delete(); b_wd_q.delete(); b_wc_q.delete();
        b_done_cnt = 0; b_done_cyc = -1;
    endtask

    // Called at posedge+1; start is high for exactly one cycle (start_cyc).
    task automatic do_start(input bit sel, input int n);
        if (!sel) begin start = 1'b1; n_instr = 11'(n); end
        else begin start_b = 1'b1; n_b = 4'(n); end
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; start_b = 1'b0;
    endtask

    // Offers words base, base+1, ... until n_words have been accepted.
    task automatic feed(input bit sel, input int n_words, input int base, input bit rnd, input int budget);
        int idx = 0;
        int t = 0;
        logic v;
        while (idx < n_words && t < budget) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!sel) begin in_vld = v; in_data = 32'(base + idx); end
            else begin in_vld_b = v; in_data_b = 32'(base + idx); end
            @(negedge clk);
            if (!sel) begin if (in_vld && in_rdy) idx++; end
            else begin if (in_vld_b && b_in_rdy) idx++; end
            @(posedge clk); #1;
            t++;
        end
        in_vld = 1'b0; in_vld_b = 1'b0;
        checks++;
        if (idx != n_words) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", idx, n_words);
        end
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int t = 0;
        while (((!sel && done_cnt == 0) || (sel && b_done_cnt == 0)) && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy: got %b want 0", in_rdy); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        checks++; if (wr_data !== 128'd0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (b_in_rdy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_b_idle: rdy %b busy %b want 0 0", b_in_rdy, b_busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Two instructions with valid held high: words 1..8.
    task automatic test_basic();
        int s;
        clear_logs();
        do_start(1'b0, 2);
        s = start_cyc;
        feed(1'b0, 8, 1, 1'b0, 100);
        wait_done(1'b0, 50);
        checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL basic_wcount: got %0d want 2", wa_q.size()); end
        if (wa_q.size() == 2 && acc_q.size() == 8) begin
            checks++; if (wa_q[0] !== 10'd0) begin errors++; $display("FAIL basic_addr0: got %0d want 0", wa_q[0]); end
            checks++; if (wd_q[0] !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL basic_data0: got %h want 00000004000000030000000200000001", wd_q[0]); end
            checks++; if (wa_q[1] !== 10'd1) begin errors++; $display("FAIL basic_addr1: got %0d want 1", wa_q[1]); end
            checks++; if (wd_q[1] !== 128'h00000008_00000007_00000006_00000005) begin errors++; $display("FAIL basic_data1: got %h want 00000008000000070000000600000005", wd_q[1]); end
            checks++; if (wc_q[0] != acc_q[3] + 1) begin errors++; $display("FAIL basic_write_lat: write at %0d want %0d", wc_q[0], acc_q[3] + 1); end
            checks++; if (wc_q[1] - wc_q[0] != 5) begin errors++; $display("FAIL basic_throughput: spacing %0d want 5", wc_q[1] - wc_q[0]); end
            checks++; if (done_cyc != wc_q[1] + 1) begin errors++; $display("FAIL basic_done_lat: done at %0d want %0d", done_cyc, wc_q[1] + 1); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc != s + 11) begin errors++; $display("FAIL basic_total_lat: done at %0d want %0d", done_cyc, s + 11); end
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 10", busy_cnt); end
    endtask

    // Zero-length load: DONE is entered straight from IDLE.
    task automatic test_zero();
        clear_logs();
        in_vld = 1'b1;
        do_start(1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        in_vld = 1'b0;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc != start_cyc + 1) begin errors++; $display("FAIL zero_done_lat: done at %0d want %0d", done_cyc, start_cyc + 1); end
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wa_q.size()); end
        checks++; if (rdy_cnt != 0) begin errors++; $display("FAIL zero_in_rdy: high %0d cycles want 0", rdy_cnt); end
    endtask

    // 16 instructions with valid toggling at random.
    task automatic test_random();
        clear_logs();
        do_start(1'b0, 16);
        feed(1'b0, 64, 256, 1'b1, 2000);
        wait_done(1'b0, 100);
        checks++; if (wa_q.size() != 16) begin errors++; $display("FAIL rand_wcount: got %0d want 16", wa_q.size()); end
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            checks++; if (wa_q[i] !== 10'(i)) begin errors++; $display("FAIL rand_addr: write %0d got %0d want %0d", i, wa_q[i], i); end
            checks++; if (wd_q[i] !== exp_a(256, i)) begin errors++; $display("FAIL rand_data: write %0d got %h want %h", i, wd_q[i], exp_a(256, i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand_done_cnt: got %0d want 1", done_cnt); end
    endtask

    // Full-depth and over-depth loads on the 8-entry instance.
    task automatic test_depth();
        clear_logs();
        do_start(1'b1, 8);
        feed(1'b1, 16, 4096, 1'b0, 200);
        wait_done(1'b1, 50);
        checks++; if (b_wa_q.size() != 8) begin errors++; $display("FAIL depth8_wcount: got %0d want 8", b_wa_q.size()); end
        if (b_wa_q.size() == 8) begin
            checks++; if (b_wa_q[7] !== 3'd7) begin errors++; $display("FAIL depth8_last_addr: got %0d want 7", b_wa_q[7]); end
            checks++; if (b_wd_q[7] !== 64'h0000100F_0000100E) begin errors++; $display("FAIL depth8_last_data: got %h want 0000100f0000100e", b_wd_q[7]); end
            checks++; if (b_done_cyc != b_wc_q[7] + 1) begin errors++; $display("FAIL depth8_done_lat: done at %0d want %0d", b_done_cyc, b_wc_q[7] + 1); end
        end
        checks++; if (b_done_cnt != 1) begin errors++; $display("FAIL depth8_done_cnt: got %0d want 1", b_done_cnt); end

        clear_logs();
        do_start(1'b1, 9);
        feed(1'b1, 16, 8192, 1'b0, 200);
        wait_done(1'b1, 50);
        checks++; if (b_wa_q.size() != 8) begin errors++; $display("FAIL clamp9_wcount: got %0d want 8", b_wa_q.size()); end
        if (b_wa_q.size() == 8) begin
            checks++; if (b_wa_q[0] !== 3'd0 || b_wa_q[7] !== 3'd7) begin errors++; $display("FAIL clamp9_addrs: first %0d last %0d want 0 7", b_wa_q[0], b_wa_q[7]); end
        end
        checks++; if (b_done_cnt != 1) begin errors++; $display("FAIL clamp9_done_cnt: got %0d want 1", b_done_cnt); end
    endtask

    // Reset after two words of the first instruction, then a fresh load.
    task automatic test_rst_abort();
        clear_logs();
        do_start(1'b0, 3);
        feed(1'b0, 2, 80, 1'b0, 50);
        rst = 1'b1;
        in_vld = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_vld = 1'b0;
        checks++; if (in_rdy !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL abort_idle: rdy %b busy %b wr_en %b want 0 0 0", in_rdy, busy, wr_en); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL abort_writes: got %0d want 0", wa_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        do_start(1'b0, 1);
        feed(1'b0, 4, 96, 1'b0, 50);
        wait_done(1'b0, 50);
        checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL reload_wcount: got %0d want 1", wa_q.size()); end
        if (wa_q.size() == 1) begin
            checks++; if (wa_q[0] !== 10'd0) begin errors++; $display("FAIL reload_addr: got %0d want 0", wa_q[0]); end
            checks++; if (wd_q[0] !== 128'h00000063_00000062_00000061_00000060) begin errors++; $display("FAIL reload_data: got %h want 00000063000000620000006100000060", wd_q[0]); end
        end
    endtask

    // A second start while loading must not change the latched count.
    task automatic test_start_ignored();
        clear_logs();
        do_start(1'b0, 2);
        feed(1'b0, 2, 512, 1'b0, 50);
        do_start(1'b0, 5);
        feed(1'b0, 6, 514, 1'b0, 50);
        wait_done(1'b0, 50);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (wa_q.size() != 2) begin errors++; $display("FAIL ign_wcount: got %0d want 2", wa_q.size()); end
        if (wa_q.size() == 2) begin
            checks++; if (wa_q[1] !== 10'd1) begin errors++; $display("FAIL ign_addr1: got %0d want 1", wa_q[1]); end
            checks++; if (wd_q[1] !== exp_a(512, 1)) begin errors++; $display("FAIL ign_data1: got %h want %h", wd_q[1], exp_a(512, 1)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle: busy %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; start_b = 1'b0;
        n_instr = 11'd0; n_b = 4'd0;
        in_data = 32'd0; in_data_b = 32'd0;
        in_vld = 1'b0; in_vld_b = 1'b0;
        clear_logs();
        test_reset();
        test_basic();
        test_zero();
        test_random();
        test_depth();
        test_rst_abort();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
